// File: rtl/fixed_point_pkg.sv
// Shared widths, accumulator sizing helper and frame FSM state type for the
// fixed-point arithmetic chain.
package fixed_point_pkg;

  localparam int WORD_LENGTH_DEF = 16;

  // Product is 2*wl wide; guard bits absorb the growth from summing many beats.
  function automatic int acc_width(input int wl, input int guard);
    return 2 * wl + guard;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } accum_state_e;

endpackage

// File: rtl/fixed_point_round_sat.sv
// Combinational round-half-up, arithmetic right shift and unsigned saturation
// from IN_W bits down to OUT_W bits.
module fixed_point_round_sat #(
  parameter int IN_W       = 40,
  parameter int OUT_W      = 16,
  parameter int FRAC_SHIFT = 8
) (
  input  logic [IN_W-1:0]  in_i,
  output logic [OUT_W-1:0] out_o,
  output logic             sat_o
);

  localparam logic [IN_W:0] HALF = (IN_W + 1)'(1) << (FRAC_SHIFT - 1);

  // One extra bit so adding the rounding constant to an all-ones input cannot wrap.
  logic [IN_W:0] rnd_d;
  logic [IN_W:0] shf_d;

  assign rnd_d = {1'b0, in_i} + HALF;
  assign shf_d = rnd_d >> FRAC_SHIFT;
  assign sat_o = |shf_d[IN_W:OUT_W];
  assign out_o = sat_o ? {OUT_W{1'b1}} : shf_d[OUT_W-1:0];

endmodule

// File: rtl/fixed_point_accum_requant.sv
// Frame accumulator with saturating sum, followed by a two-register requantize
// pipeline that delivers one rounded, saturated WORD_LENGTH result per frame.
//
//   state | meaning
//   IDLE  | no frame open; next accepted beat starts a frame
//   ACCUM | at least one beat accepted, last beat not yet seen
module fixed_point_accum_requant
  import fixed_point_pkg::*;
#(
  parameter int WORD_LENGTH = WORD_LENGTH_DEF,
  parameter int ACC_GUARD   = 8,
  parameter int FRAC_SHIFT  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_i,
  input  logic                     last_i,
  input  logic [2*WORD_LENGTH-1:0] prod_i,
  output logic [WORD_LENGTH-1:0]   y_o,
  output logic                     valid_o,
  output logic                     sat_o,
  output logic                     ovf_o,
  output logic                     busy_o
);

  localparam int ACC_W = acc_width(WORD_LENGTH, ACC_GUARD);

  accum_state_e     state_q;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic [ACC_W-1:0] frame_q;
  logic             frame_ovf_q;
  logic             frame_vld_q;

  logic [ACC_W:0]   sum_d;
  logic [ACC_W-1:0] acc_d;
  logic             ovf_d;

  logic [WORD_LENGTH-1:0] rq_y_d;
  logic                   rq_sat_d;

  logic [WORD_LENGTH-1:0] rs_y_q;
  logic                   rs_sat_q;
  logic                   rs_ovf_q;
  logic                   rs_vld_q;

  logic [WORD_LENGTH-1:0] y_q;
  logic                   valid_q;
  logic                   sat_q;
  logic                   ovf_o_q;

  // Once clamped, the sum stays at max because any further product re-overflows.
  assign sum_d = {1'b0, acc_q} + (ACC_W + 1)'(prod_i);
  assign acc_d = sum_d[ACC_W] ? {ACC_W{1'b1}} : sum_d[ACC_W-1:0];
  assign ovf_d = ovf_q | sum_d[ACC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      frame_q     <= '0;
      frame_ovf_q <= 1'b0;
      frame_vld_q <= 1'b0;
    end else begin
      frame_vld_q <= 1'b0;
      if (valid_i) begin
        if (last_i) begin
          frame_q     <= acc_d;
          frame_ovf_q <= ovf_d;
          frame_vld_q <= 1'b1;
          acc_q       <= '0;
          ovf_q       <= 1'b0;
          state_q     <= IDLE;
        end else begin
          acc_q   <= acc_d;
          ovf_q   <= ovf_d;
          state_q <= ACCUM;
        end
      end
    end
  end

  fixed_point_round_sat #(
    .IN_W       (ACC_W),
    .OUT_W      (WORD_LENGTH),
    .FRAC_SHIFT (FRAC_SHIFT)
  ) u_round_sat (
    .in_i  (frame_q),
    .out_o (rq_y_d),
    .sat_o (rq_sat_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_y_q   <= '0;
      rs_sat_q <= 1'b0;
      rs_ovf_q <= 1'b0;
      rs_vld_q <= 1'b0;
      y_q      <= '0;
      sat_q    <= 1'b0;
      ovf_o_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      rs_vld_q <= frame_vld_q;
      if (frame_vld_q) begin
        rs_y_q   <= rq_y_d;
        rs_sat_q <= rq_sat_d;
        rs_ovf_q <= frame_ovf_q;
      end
      valid_q <= rs_vld_q;
      if (rs_vld_q) begin
        y_q     <= rs_y_q;
        sat_q   <= rs_sat_q;
        ovf_o_q <= rs_ovf_q;
      end
    end
  end

  assign y_o     = y_q;
  assign valid_o = valid_q;
  assign sat_o   = sat_q;
  assign ovf_o   = ovf_o_q;
  assign busy_o  = (state_q == ACCUM);

endmodule

// File: tb/tb_fixed_point_accum_requant.sv
// Directed bench: an arithmetic frame model checks every output each cycle,
// and per-scenario literal results pin the model.
module tb_fixed_point_accum_requant;

  localparam int  WL     = 16;
  localparam int  GUARD  = 8;
  localparam int  FS     = 8;
  localparam int  AW     = 2 * WL + GUARD;
  localparam longint MAXACC = (longint'(1) << AW) - 1;
  localparam longint MAXY   = (longint'(1) << WL) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            valid_i = 1'b0;
  logic            last_i = 1'b0;
  logic [2*WL-1:0] prod_i = '0;
  logic [WL-1:0]   y_o;
  logic            valid_o, sat_o, ovf_o, busy_o;

  fixed_point_accum_requant #(
    .WORD_LENGTH (WL),
    .ACC_GUARD   (GUARD),
    .FRAC_SHIFT  (FS)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (valid_i),
    .last_i  (last_i),
    .prod_i  (prod_i),
    .y_o     (y_o),
    .valid_o (valid_o),
    .sat_o   (sat_o),
    .ovf_o   (ovf_o),
    .busy_o  (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint      due;
    logic [15:0] y;
    logic        sat;
    logic        ovf;
  } res_t;

  int     n_pass = 0;
  int     n_total = 0;
  longint edge_n = 0;
  res_t   exp_q[$];
  res_t   obs_q[$];

  longint m_acc = 0;
  logic   m_ovf = 1'b0;
  logic   m_open = 1'b0;
  res_t   held = '{0, 16'h0, 1'b0, 1'b0};

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
  endtask

  function automatic res_t requant(input longint frame, input logic ovf, input longint due);
    res_t   r;
    longint q;
    q = (frame + (longint'(1) << (FS - 1))) >> FS;
    r.due = due;
    r.sat = (q > MAXY);
    r.y   = r.sat ? 16'hFFFF : q[15:0];
    r.ovf = ovf;
    return r;
  endfunction

  always @(posedge clk) begin
    logic exp_v;
    edge_n++;
    if (!rst_n) begin
      m_acc = 0; m_ovf = 1'b0; m_open = 1'b0;
      exp_q.delete();
      held = '{0, 16'h0, 1'b0, 1'b0};
    end else if (valid_i) begin
      m_acc = m_acc + longint'(prod_i);
      if (m_acc > MAXACC) begin
        m_acc = MAXACC;
        m_ovf = 1'b1;
      end
      if (last_i) begin
        exp_q.push_back(requant(m_acc, m_ovf, edge_n + 2));
        m_acc = 0; m_ovf = 1'b0; m_open = 1'b0;
      end else begin
        m_open = 1'b1;
      end
    end
    #1;
    if (!rst_n) begin
      chk("rst_valid", 64'(valid_o), 64'd0);
      chk("rst_y",     64'(y_o),     64'd0);
      chk("rst_sat",   64'(sat_o),   64'd0);
      chk("rst_ovf",   64'(ovf_o),   64'd0);
      chk("rst_busy",  64'(busy_o),  64'd0);
    end else begin
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == edge_n);
      if (exp_v) held = exp_q.pop_front();
      chk("valid_o", 64'(valid_o), 64'(exp_v));
      chk("y_o",     64'(y_o),     64'(held.y));
      chk("sat_o",   64'(sat_o),   64'(held.sat));
      chk("ovf_o",   64'(ovf_o),   64'(held.ovf));
      chk("busy_o",  64'(busy_o),  64'(m_open));
      if (valid_o) obs_q.push_back('{edge_n, y_o, sat_o, ovf_o});
    end
  end

  task automatic beat(input logic [31:0] p, input logic l);
    @(negedge clk);
    valid_i = 1'b1; prod_i = p; last_i = l;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_i = 1'b0; last_i = 1'b0; prod_i = '0;
    end
  endtask

  task automatic lit(input string nm, input int idx, input logic [15:0] y,
                     input logic sat, input logic ovf);
    if (obs_q.size() <= idx) begin
      n_total++;
      $display("FAIL %s missing result %0d got_count=%0d", nm, idx, obs_q.size());
    end else begin
      chk({nm, "_y"},   64'(obs_q[idx].y),   64'(y));
      chk({nm, "_sat"}, 64'(obs_q[idx].sat), 64'(sat));
      chk({nm, "_ovf"}, 64'(obs_q[idx].ovf), 64'(ovf));
    end
  endtask

  task automatic lit_count(input string nm, input int n);
    chk({nm, "_count"}, 64'(obs_q.size()), 64'(n));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    obs_q.delete();
    beat(32'd5000, 1'b1);
    idle(5);
    lit_count("single", 1);
    lit("single", 0, 16'd20, 1'b0, 1'b0);

    obs_q.delete();
    beat(32'd384, 1'b1);
    beat(32'd383, 1'b1);
    beat(32'd127, 1'b1);
    idle(5);
    lit_count("round", 3);
    lit("round384", 0, 16'd2, 1'b0, 1'b0);
    lit("round383", 1, 16'd1, 1'b0, 1'b0);
    lit("round127", 2, 16'd0, 1'b0, 1'b0);

    obs_q.delete();
    beat(32'd5000, 1'b0);
    beat(32'd125460000, 1'b1);
    idle(5);
    lit_count("sat", 1);
    lit("sat", 0, 16'hFFFF, 1'b1, 1'b0);

    obs_q.delete();
    for (int i = 0; i < 257; i++) beat(32'hFFFE0001, (i == 256));
    beat(32'd5000, 1'b1);
    idle(5);
    lit_count("ovf", 2);
    lit("ovf", 0, 16'hFFFF, 1'b1, 1'b1);
    lit("post_ovf", 1, 16'd20, 1'b0, 1'b0);

    obs_q.delete();
    beat(32'd100, 1'b0);
    beat(32'd200, 1'b1);
    beat(32'd1000, 1'b1);
    idle(5);
    lit_count("b2b", 2);
    lit("b2b_a", 0, 16'd1, 1'b0, 1'b0);
    lit("b2b_b", 1, 16'd4, 1'b0, 1'b0);

    obs_q.delete();
    beat(32'd300, 1'b0);
    @(negedge clk);
    valid_i = 1'b0; last_i = 1'b1; prod_i = 32'd7777;
    beat(32'd100, 1'b1);
    idle(5);
    lit_count("gap_last", 1);
    lit("gap_last", 0, 16'd2, 1'b0, 1'b0);

    obs_q.delete();
    beat(32'd100, 1'b0);
    beat(32'd200, 1'b0);
    @(negedge clk);
    valid_i = 1'b0; last_i = 1'b0; prod_i = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    beat(32'd512, 1'b1);
    idle(5);
    lit_count("rst_mid", 1);
    lit("rst_mid", 0, 16'd2, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
